// File: rtl/hyper_arb_pkg.sv
// Shared definitions for the HyperBus burst round-robin arbiter.
//   arb_state_e : arbiter FSM state (idle / burst locked).
//   ch_width()  : width of a channel index for a given channel count.
package hyper_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Channel-index width. A single channel still gets a 1-bit index so
  // that index ports never collapse to zero width.
  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/hyper_rr_pick.sv
// Combinational rotate-priority picker.
//   req_i    : request vector, one bit per channel.
//   ptr_i    : channel that currently has the highest priority.
//   onehot_o : one-hot winner (all zero when nothing requests).
//   idx_o    : winner index (0 when nothing requests).
//   valid_o  : at least one channel requests.
module hyper_rr_pick
  import hyper_arb_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = ch_width(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [N_CH-1:0] onehot_o,
  output logic [CH_W-1:0] idx_o,
  output logic            valid_o
);

  int              cand;
  logic [CH_W-1:0] cand_idx;

  // Scan ptr, ptr+1, ... (mod N_CH); the first requester found wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write;
    // a path that leaves one unassigned would infer a latch.
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= N_CH) cand = cand - N_CH;
      cand_idx = CH_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o            = 1'b1;
        idx_o              = cand_idx;
        onehot_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hyper_burst_rr_arbiter.sv
// Round-robin arbiter with burst locking that shares the single HyperBus
// command/data port between uDMA channels.
//   clk_i, rst_ni    : clock, asynchronous active-low reset.
//   req_i, last_i    : per-channel beat request / final-beat flag.
//   gnt_o            : per-channel grant (one-hot or zero).
//   data_i, id_i     : per-channel payload and ID, packed channel 0 lowest.
//   req_o, gnt_i     : request to / grant from the HyperBus controller.
//   data_o, id_o     : payload and ID of the selected channel.
//   ch_o             : index of the selected channel.
//   busy_o           : a burst is locked to one channel.
// A winner owns the port until its last beat or until MAX_BEATS beats
// (0 = no cap) have been transferred; priority then rotates to the
// channel after the one that just finished.
module hyper_burst_rr_arbiter
  import hyper_arb_pkg::*;
#(
  parameter  int N_CH       = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int ID_WIDTH   = 4,
  parameter  int MAX_BEATS  = 0,
  localparam int CH_W       = ch_width(N_CH)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [N_CH-1:0]            req_i,
  input  logic [N_CH-1:0]            last_i,
  output logic [N_CH-1:0]            gnt_o,
  input  logic [N_CH*DATA_WIDTH-1:0] data_i,
  input  logic [N_CH*ID_WIDTH-1:0]   id_i,
  output logic                       req_o,
  input  logic                       gnt_i,
  output logic [DATA_WIDTH-1:0]      data_o,
  output logic [ID_WIDTH-1:0]        id_o,
  output logic [CH_W-1:0]            ch_o,
  output logic                       busy_o
);

  arb_state_e      state_q, state_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0] owner_q, owner_d;
  logic [15:0]     beat_cnt_q, beat_cnt_d;

  logic [N_CH-1:0] pick_onehot;
  logic [CH_W-1:0] pick_idx;
  logic            pick_valid;

  logic            locked;
  logic [CH_W-1:0] sel;
  logic [CH_W-1:0] sel_next;
  logic            handshake;
  int              beats_done;
  logic            cap_hit;

  hyper_rr_pick #(
    .N_CH (N_CH)
  ) u_pick (
    .req_i    (req_i),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  assign locked = (state_q == ARB_LOCKED);

  // Channel selection and the controller-side handshake. While locked only
  // the owner is visible; in idle the picker's winner is shown, falling back
  // to rr_ptr so the data/id muxes always point at a defined channel.
  always_comb begin
    sel   = rr_ptr_q;
    req_o = 1'b0;
    gnt_o = '0;
    if (locked) begin
      sel            = owner_q;
      req_o          = req_i[owner_q];
      gnt_o[owner_q] = gnt_i;
    end else begin
      if (pick_valid) sel = pick_idx;
      req_o = |req_i;
      gnt_o = pick_onehot & {N_CH{gnt_i}};
    end
    // Grants must be silent while reset is asserted, even in idle where
    // they would otherwise follow gnt_i combinationally.
    if (!rst_ni) gnt_o = '0;
  end

  assign data_o    = data_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign id_o      = id_i[int'(sel)*ID_WIDTH +: ID_WIDTH];
  assign ch_o      = sel;
  assign busy_o    = locked;
  assign handshake = req_o & gnt_i;

  assign sel_next = (sel == CH_W'(N_CH - 1)) ? '0 : sel + CH_W'(1);

  // Beats of the current burst including this one. In idle the counter may
  // hold a stale value, so the first beat is always counted as 1; this also
  // makes MAX_BEATS = 1 release on every beat without ever locking.
  assign beats_done = locked ? int'(beat_cnt_q) + 1 : 1;
  assign cap_hit    = (MAX_BEATS != 0) && (beats_done == MAX_BEATS);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    if (handshake) begin
      beat_cnt_d = 16'(beats_done);
      if (last_i[sel] || cap_hit) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = sel_next;
      end else begin
        state_d = ARB_LOCKED;
        owner_d = sel;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_hyper_burst_rr_arbiter.sv
// Self-checking bench for hyper_burst_rr_arbiter. Two instances share the
// same stimulus: one without a beat cap and one with MAX_BEATS = 4. Each has
// its own reference model built from the arbitration rules (priority scan,
// burst ownership, beat counting, rotation after each burst).
module tb_hyper_burst_rr_arbiter;

  localparam int N_CH = 4;
  localparam int DW   = 32;
  localparam int IW   = 4;

  logic               clk = 1'b0;
  logic               rst_ni;
  logic [N_CH-1:0]    req;
  logic [N_CH-1:0]    last;
  logic               gnt;
  logic [N_CH*DW-1:0] data;
  logic [N_CH*IW-1:0] id;

  logic [N_CH-1:0]    gnt_o_w  [2];
  logic               req_o_w  [2];
  logic [DW-1:0]      data_o_w [2];
  logic [IW-1:0]      id_o_w   [2];
  logic [1:0]         ch_o_w   [2];
  logic               busy_o_w [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit locked;
    int owner;
    int ptr;
    int beats;
  } model_t;

  model_t m [2];
  int     cap [2] = '{0, 4};

  always #5 clk = ~clk;

  hyper_burst_rr_arbiter #(
    .N_CH (N_CH), .DATA_WIDTH (DW), .ID_WIDTH (IW), .MAX_BEATS (0)
  ) dut0 (
    .clk_i (clk), .rst_ni (rst_ni), .req_i (req), .last_i (last),
    .gnt_o (gnt_o_w[0]), .data_i (data), .id_i (id), .req_o (req_o_w[0]),
    .gnt_i (gnt), .data_o (data_o_w[0]), .id_o (id_o_w[0]),
    .ch_o (ch_o_w[0]), .busy_o (busy_o_w[0])
  );

  hyper_burst_rr_arbiter #(
    .N_CH (N_CH), .DATA_WIDTH (DW), .ID_WIDTH (IW), .MAX_BEATS (4)
  ) dut4 (
    .clk_i (clk), .rst_ni (rst_ni), .req_i (req), .last_i (last),
    .gnt_o (gnt_o_w[1]), .data_i (data), .id_i (id), .req_o (req_o_w[1]),
    .gnt_i (gnt), .data_o (data_o_w[1]), .id_o (id_o_w[1]),
    .ch_o (ch_o_w[1]), .busy_o (busy_o_w[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel the model expects to be selected, or -1 when nobody requests.
  function automatic int winner(input model_t mm);
    int c;
    if (mm.locked) return mm.owner;
    for (int k = 0; k < N_CH; k++) begin
      c = (mm.ptr + k) % N_CH;
      if (req[2'(c)]) return c;
    end
    return -1;
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.locked = 1'b0;
    r.owner  = 0;
    r.ptr    = 0;
    r.beats  = 0;
    return r;
  endfunction

  task automatic randomize_payload();
    data = {$urandom, $urandom, $urandom, $urandom};
    id   = 16'($urandom);
  endtask

  // One clock cycle: inputs already driven; compare outputs mid-cycle,
  // advance both models by the rules, then cross the rising edge.
  task automatic step(input string tag);
    int              w;
    int              sel;
    int              done;
    logic            e_req;
    logic [N_CH-1:0] e_gnt;
    bit              fin;
    #2;
    for (int d = 0; d < 2; d++) begin
      w     = winner(m[d]);
      sel   = (w < 0) ? m[d].ptr : w;
      e_req = m[d].locked ? req[2'(m[d].owner)] : (w >= 0);
      e_gnt = '0;
      if (w >= 0 && gnt) e_gnt[2'(w)] = 1'b1;
      check($sformatf("%s/d%0d/req_o", tag, d), 32'(req_o_w[d]), 32'(e_req));
      check($sformatf("%s/d%0d/gnt_o", tag, d), 32'(gnt_o_w[d]), 32'(e_gnt));
      check($sformatf("%s/d%0d/ch_o", tag, d), 32'(ch_o_w[d]), sel);
      check($sformatf("%s/d%0d/data_o", tag, d), data_o_w[d], data[sel*DW +: DW]);
      check($sformatf("%s/d%0d/id_o", tag, d), 32'(id_o_w[d]), 32'(id[sel*IW +: IW]));
      check($sformatf("%s/d%0d/busy_o", tag, d), 32'(busy_o_w[d]), 32'(m[d].locked));
      if (e_req && gnt) begin
        done = m[d].locked ? m[d].beats + 1 : 1;
        fin  = last[2'(sel)] || (cap[d] != 0 && done == cap[d]);
        if (fin) begin
          m[d].locked = 1'b0;
          m[d].ptr    = (sel + 1) % N_CH;
          m[d].beats  = 0;
        end else begin
          m[d].locked = 1'b1;
          m[d].owner  = sel;
          m[d].beats  = done;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Explicit channel check on both instances before the regular step.
  task automatic peek_ch(input string tag, input int exp_ch);
    #1;
    check({tag, "/d0"}, 32'(ch_o_w[0]), exp_ch);
    check({tag, "/d1"}, 32'(ch_o_w[1]), exp_ch);
  endtask

  // Asynchronous reset: outputs must go quiet before any clock edge.
  task automatic apply_reset(input string tag);
    rst_ni = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s/d%0d/busy_o", tag, d), 32'(busy_o_w[d]), 0);
      check($sformatf("%s/d%0d/gnt_o", tag, d), 32'(gnt_o_w[d]), 0);
      m[d] = model_reset();
    end
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b1;
    req    = '0;
    last   = '0;
    gnt    = 1'b0;
    randomize_payload();
    #1;
    apply_reset("reset");

    // Idle after reset: nothing requests, channel 0 is shown.
    peek_ch("idle_ch", 0);
    step("idle");

    // Single-beat requests from channels 1 and 3 alternate.
    req  = 4'b1010;
    last = 4'b1111;
    gnt  = 1'b1;
    peek_ch("rr_c0", 1);
    step("rr0");
    peek_ch("rr_c1", 3);
    step("rr1");
    peek_ch("rr_c2", 1);
    step("rr2");

    // Channel 2 four-beat burst while channel 0 keeps requesting.
    req = 4'b0101;
    for (int b = 1; b <= 4; b++) begin
      last = (b == 4) ? 4'b0100 : 4'b0000;
      randomize_payload();
      step($sformatf("burst_b%0d", b));
    end
    req  = 4'b0001;
    last = 4'b1111;
    peek_ch("wrap_ch", 0);
    step("wrap");

    // Channel 1 locks, then drops its request for three cycles.
    req  = 4'b0010;
    last = 4'b0000;
    step("wait_lock");
    req = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      randomize_payload();
      step($sformatf("wait_%0d", k));
    end
    req  = 4'b1111;
    last = 4'b0010;
    step("wait_end");
    req  = 4'b0100;
    last = 4'b1111;
    step("to_ptr3");

    // Long burst from channel 1 with channel 2 also requesting; the capped
    // instance releases after beat 4 and hands over to channel 2.
    req  = 4'b0110;
    last = 4'b0000;
    for (int b = 1; b <= 10; b++) begin
      randomize_payload();
      if (b == 5) begin
        #1;
        check("cap_busy", 32'(busy_o_w[1]), 0);
        check("cap_ch", 32'(ch_o_w[1]), 2);
      end
      step($sformatf("cap_b%0d", b));
    end
    last = 4'b1111;
    for (int k = 0; k < 4; k++) step($sformatf("cap_drain%0d", k));

    // Controller stalls for five cycles with requests pending.
    req = 4'b1001;
    gnt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      randomize_payload();
      step($sformatf("stall_%0d", k));
    end
    gnt = 1'b1;
    step("stall_go");

    // Reset in the middle of a locked burst.
    req  = 4'b0100;
    last = 4'b0000;
    step("rst_lock0");
    step("rst_lock1");
    req = 4'b1111;
    apply_reset("mid_reset");
    last = 4'b1111;
    peek_ch("post_reset_ch", 0);
    step("post_reset");

    // Randomized traffic against the models.
    for (int k = 0; k < 400; k++) begin
      req  = 4'($urandom);
      gnt  = ($urandom_range(0, 3) != 0);
      last = 4'($urandom) & 4'($urandom);
      randomize_payload();
      step($sformatf("rand_%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
